// File: rtl/io_timer_if.sv
// ============================================================================
// Module   : io_timer_if
// Purpose  : Per-device bridge port (Addr/WE/Din/Dout) plus IRQ for io_timer.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface io_timer_if;
    logic [31:0] Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        IRQ;

    modport master (
        output Addr,
        output WE,
        output Din,
        input  Dout,
        input  IRQ
    );

    modport slave (
        input  Addr,
        input  WE,
        input  Din,
        output Dout,
        output IRQ
    );
endinterface

`default_nettype wire

// File: rtl/io_timer.sv
// ============================================================================
// Module   : io_timer
// Purpose  : Memory-mapped 32-bit down-counting timer, one-shot or periodic.
// Revision : 1.0
// ============================================================================
`default_nettype none

module io_timer (
    input  wire logic  clk,
    input  wire logic  reset,
    io_timer_if.slave  bus
);

    localparam logic [1:0] c_OFF_CTRL   = 2'b00;
    localparam logic [1:0] c_OFF_PRESET = 2'b01;
    localparam logic [1:0] c_OFF_COUNT  = 2'b10;
    localparam logic [1:0] c_MODE_PER   = 2'b01;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_t;

    state_t      state_q;
    logic [3:0]  ctrl_q;
    logic [3:0]  ctrl_d;
    logic [31:0] preset_q;
    logic [31:0] count_q;
    logic        pend_q;
    logic        pend_d;
    logic [31:0] w_dout;

    wire logic w_wr_ctrl   = bus.WE && (bus.Addr[3:2] == c_OFF_CTRL);
    wire logic w_wr_preset = bus.WE && (bus.Addr[3:2] == c_OFF_PRESET);
    wire logic w_enable    = ctrl_q[0];
    wire logic w_periodic  = (ctrl_q[2:1] == c_MODE_PER);
    wire logic w_expire    = (state_q == S_CNT) && w_enable && (count_q <= 32'd1);
    wire logic w_unused    = &{1'b0, bus.Addr[31:4], bus.Addr[1:0]};

    // Priority: CPU write beats one-shot auto-disable; expiry set beats write-clear.
    always_comb begin
        ctrl_d = ctrl_q;
        if ((state_q == S_INT) && !w_periodic) begin
            ctrl_d[0] = 1'b0;
        end
        if (w_wr_ctrl) begin
            ctrl_d = bus.Din[3:0];
        end

        pend_d = pend_q;
        if ((state_q == S_INT) && w_periodic) begin
            pend_d = 1'b0;
        end
        if (w_wr_ctrl) begin
            pend_d = 1'b0;
        end
        if (w_expire) begin
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            ctrl_q   <= 4'd0;
            preset_q <= 32'd0;
            count_q  <= 32'd0;
            pend_q   <= 1'b0;
        end else begin
            ctrl_q <= ctrl_d;
            pend_q <= pend_d;
            if (w_wr_preset) begin
                preset_q <= bus.Din;
            end

            case (state_q)
                S_IDLE: begin
                    if (w_enable) begin
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    count_q <= preset_q;
                    state_q <= S_CNT;
                end
                S_CNT: begin
                    if (!w_enable) begin
                        state_q <= S_IDLE;
                    end else if (count_q > 32'd1) begin
                        count_q <= count_q - 32'd1;
                    end else begin
                        count_q <= 32'd0;
                        state_q <= S_INT;
                    end
                end
                S_INT: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        w_dout = 32'd0;
        case (bus.Addr[3:2])
            c_OFF_CTRL:   w_dout = {28'd0, ctrl_q};
            c_OFF_PRESET: w_dout = preset_q;
            c_OFF_COUNT:  w_dout = count_q;
            default:      w_dout = 32'd0;
        endcase
    end

    assign bus.Dout = w_dout;
    assign bus.IRQ  = ctrl_q[3] & pend_q;

endmodule

`default_nettype wire

// File: tb/tb_io_timer.sv
// ============================================================================
// Module   : tb_io_timer
// Purpose  : Directed self-checking bench for io_timer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_io_timer;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_fail;

    io_timer_if bus ();

    io_timer u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [31:0] raddr;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.Addr = a;
        bus.Din  = d;
        bus.WE   = 1'b1;
        @(posedge clk);
        #1;
        bus.WE   = 1'b0;
        bus.Din  = 32'd0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        bus.Addr = a;
        #1;
        d = bus.Dout;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    initial begin
        logic [31:0] d;
        bit          found;

        n_cmp    = 0;
        n_fail   = 0;
        reset    = 1'b1;
        bus.Addr = 32'd0;
        bus.Din  = 32'd0;
        bus.WE   = 1'b0;

        vecs[0]  = '{1'b0, 32'h7F00, 32'h0,        32'h7F00, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 32'h7F00, 32'h0,        32'h7F04, 32'h0,        1'b0};
        vecs[2]  = '{1'b0, 32'h7F00, 32'h0,        32'h7F08, 32'h0,        1'b0};
        vecs[3]  = '{1'b0, 32'h7F00, 32'h0,        32'h7F0C, 32'h0,        1'b0};
        vecs[4]  = '{1'b1, 32'h7F04, 32'hDEADBEEF, 32'h7F04, 32'hDEADBEEF, 1'b0};
        vecs[5]  = '{1'b1, 32'h7F18, 32'h00001234, 32'h7F08, 32'h0,        1'b0};
        vecs[6]  = '{1'b1, 32'h7F0C, 32'hFFFFFFFF, 32'h7F0C, 32'h0,        1'b0};
        vecs[7]  = '{1'b1, 32'h7F10, 32'hFFFFFFF0, 32'h7F00, 32'h0,        1'b0};
        vecs[8]  = '{1'b1, 32'h7F00, 32'h00000006, 32'h7F00, 32'h6,        1'b0};
        vecs[9]  = '{1'b1, 32'h7F14, 32'hA5A5A5A5, 32'h7F14, 32'hA5A5A5A5, 1'b0};
        vecs[10] = '{1'b1, 32'h7F00, 32'h0,        32'h7F00, 32'h0,        1'b0};
        vecs[11] = '{1'b1, 32'h7F04, 32'h0,        32'h7F04, 32'h0,        1'b0};

        repeat (3) tick();
        check("rst_irq", {31'd0, bus.IRQ}, 32'd0);
        reset = 1'b0;
        tick();

        // Register map rules
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].we) wr(vecs[i].waddr, vecs[i].wdata);
            else            tick();
            rd(vecs[i].raddr, d);
            check($sformatf("vec%0d_rd", i), d, vecs[i].exp_rd);
            check($sformatf("vec%0d_irq", i), {31'd0, bus.IRQ}, {31'd0, vecs[i].exp_irq});
        end

        // Mode 0 one-shot, PRESET=5
        wr(32'h7F04, 32'd5);
        wr(32'h7F00, 32'h9);
        tick();
        for (int k = 5; k >= 0; k--) begin
            tick();
            rd(32'h7F08, d);
            check($sformatf("m0_count%0d", k), d, k);
            check($sformatf("m0_irq%0d", k), {31'd0, bus.IRQ}, (k == 0) ? 32'd1 : 32'd0);
        end
        tick();
        rd(32'h7F00, d);
        check("m0_ctrl", d, 32'h8);
        repeat (3) tick();
        check("m0_irq_hold", {31'd0, bus.IRQ}, 32'd1);
        wr(32'h7F00, 32'h8);
        check("m0_ack", {31'd0, bus.IRQ}, 32'd0);

        // Mode 1 periodic, PRESET=3: pulse after edges 5, 11, 17, 23
        wr(32'h7F04, 32'd3);
        wr(32'h7F00, 32'hB);
        for (int i = 1; i <= 24; i++) begin
            tick();
            check($sformatf("m1_irq%0d", i), {31'd0, bus.IRQ}, (i % 6 == 5) ? 32'd1 : 32'd0);
        end
        rd(32'h7F00, d);
        check("m1_ctrl", d, 32'hB);
        wr(32'h7F00, 32'h0);
        repeat (3) tick();

        // Pause at COUNT=60
        wr(32'h7F04, 32'd100);
        wr(32'h7F00, 32'h9);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            tick();
            rd(32'h7F08, d);
            if (d == 32'd60) found = 1'b1;
        end
        check("pause_reach60", {31'd0, found}, 32'd1);
        wr(32'h7F00, 32'h0);
        repeat (5) tick();
        rd(32'h7F08, d);
        check("pause_count", d, 32'd59);
        check("pause_irq", {31'd0, bus.IRQ}, 32'd0);
        wr(32'h7F08, 32'h1234);
        rd(32'h7F08, d);
        check("count_ro", d, 32'd59);
        rd(32'h7F0C, d);
        check("off_c", d, 32'd0);

        // Masked interrupt
        wr(32'h7F04, 32'd2);
        wr(32'h7F00, 32'h1);
        repeat (10) tick();
        check("mask_irq", {31'd0, bus.IRQ}, 32'd0);
        rd(32'h7F00, d);
        check("mask_ctrl", d, 32'h0);
        wr(32'h7F00, 32'h8);
        check("mask_ack_irq0", {31'd0, bus.IRQ}, 32'd0);
        tick();
        check("mask_ack_irq1", {31'd0, bus.IRQ}, 32'd0);

        // CTRL write colliding with one-shot INT edge
        wr(32'h7F04, 32'd2);
        wr(32'h7F00, 32'h9);
        repeat (3) tick();
        check("col_pre_irq", {31'd0, bus.IRQ}, 32'd0);
        tick();
        check("col_int_irq", {31'd0, bus.IRQ}, 32'd1);
        wr(32'h7F00, 32'hB);
        rd(32'h7F00, d);
        check("col_ctrl", d, 32'hB);
        check("col_clr_irq", {31'd0, bus.IRQ}, 32'd0);
        for (int i = 1; i <= 10; i++) begin
            tick();
            check($sformatf("col_irq%0d", i), {31'd0, bus.IRQ}, (i == 4 || i == 9) ? 32'd1 : 32'd0);
        end
        wr(32'h7F00, 32'h0);
        repeat (3) tick();

        // Asynchronous reset mid-count
        wr(32'h7F04, 32'h40);
        wr(32'h7F00, 32'h9);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            tick();
            rd(32'h7F08, d);
            if (d == 32'h20) found = 1'b1;
        end
        check("rst_reach20", {31'd0, found}, 32'd1);
        reset = 1'b1;
        rd(32'h7F08, d);
        check("rst_count", d, 32'd0);
        rd(32'h7F00, d);
        check("rst_ctrl", d, 32'd0);
        rd(32'h7F04, d);
        check("rst_preset", d, 32'd0);
        check("rst_irq_mid", {31'd0, bus.IRQ}, 32'd0);
        #1;
        reset = 1'b0;
        wr(32'h7F04, 32'd7);
        for (int i = 0; i < 10; i++) begin
            tick();
            rd(32'h7F08, d);
            check($sformatf("rst_idle%0d", i), d, 32'd0);
        end
        wr(32'h7F00, 32'h9);
        repeat (2) tick();
        rd(32'h7F08, d);
        check("rst_resume", d, 32'd7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/io_timer.md
Name: io_timer

Overview:
- Memory-mapped down-counting timer that responds on the bridge's per-device port (Addr/WE/Din/Dout).
- Two instances sit behind the bridge: Timer0 at 0x0000_7F00–0x0000_7F0B and Timer1 at 0x0000_7F10–0x0000_7F1B.
- Each instance raises IRQ toward the CPU's external-interrupt input when its count expires.
- Supports one-shot (mode 0) and auto-reload periodic (mode 1) operation.

Parameters:
- none (the base address is decoded by the bridge; the block decodes only word offset Addr[3:2])

Ports:
- clk    input   1   system clock, all state updates on rising edge
- reset  input   1   asynchronous, active-high reset
- Addr   input   32  byte address from the bridge; only Addr[3:2] used
- WE     input   1   write enable, already qualified by the bridge's address range; word writes only
- Din    input   32  write data
- Dout   output  32  read data, combinational from Addr[3:2] and current registers
- IRQ    output  1   interrupt request, level, = CTRL.IM & irq_pending

Behaviour:
- Register map (Addr[3:2]):
  - 00 CTRL: [0] Enable, [2:1] Mode, [3] IM. Bits [31:4] read 0 and writes to them are discarded.
  - 01 PRESET: 32-bit reload value, read/write.
  - 10 COUNT: 32-bit current count, read-only; writes ignored.
  - 11: reads 32'h0; writes ignored.
- Mode decode: Mode==2'b01 → periodic (mode 1); any other value → one-shot (mode 0). Mode is stored as written.
- Reset (async): CTRL=0, PRESET=0, COUNT=0, irq_pending=0, state=IDLE. IRQ=0 and Dout=0 for every address.
- FSM (registered), evaluated on the registered CTRL value each edge:
  - IDLE: Enable=1 → LOAD; else stay. COUNT holds.
  - LOAD: COUNT<=PRESET → CNT.
  - CNT:
    - Enable=0 → IDLE, COUNT holds.
    - else COUNT>1 → COUNT<=COUNT-1, stay.
    - else (COUNT<=1) → COUNT<=0, irq_pending<=1 → INT.
  - INT, mode 0: CTRL.Enable<=0, → IDLE. irq_pending stays set.
  - INT, mode 1: irq_pending<=0, → IDLE with Enable kept, so the timer reloads automatically.
- Timing:
  - Mode 0: IRQ rises PRESET+2 edges after the edge that writes CTRL.Enable=1 (PRESET≥1). PRESET=0 behaves as PRESET=1.
  - Mode 1: IRQ is high exactly 1 cycle (the INT state). Period is PRESET+3 cycles (PRESET≥1).
- irq_pending clear: any write to CTRL clears it (mode 0 acknowledge). Mode 1 clears it in the INT state as described above.
- Simultaneous events:
  - A CPU write to CTRL on the same edge as the mode-0 INT auto-clear of Enable: the CPU write wins for all CTRL bits, and irq_pending is cleared.
  - If the same edge also enters INT, set wins over the write-clear.
  - A PRESET write during CNT does not affect the current count; it takes effect at the next LOAD.
  - A CTRL write with Enable=0 during CNT: the FSM sees Enable=0 on the following edge, goes to IDLE, and COUNT freezes at its value then.
  - IM=0 masks IRQ only; irq_pending still sets and is visible by setting IM later.
- Reset asserted mid-count returns everything to reset values immediately, with no IRQ glitch. Counting resumes only after software rewrites CTRL.
- COUNT never wraps: the decrement happens only when COUNT>1.

Test Plan:
- Reset check: assert reset mid-CNT with COUNT=0x20 → COUNT, CTRL, and PRESET read 0 and IRQ=0 immediately. After release, state stays IDLE for 10 cycles.
- Mode 0 one-shot: write PRESET=5, then CTRL=0x9.
  - COUNT reads 5,4,3,2,1,0 on successive cycles after LOAD.
  - IRQ rises 7 edges after the CTRL write and stays high; CTRL reads 0x8.
  - Writing CTRL=0x8 drops IRQ the next cycle.
- Mode 1 periodic: write PRESET=3, then CTRL=0xB → IRQ pulses for 1 cycle, repeating every 6 cycles for at least 4 periods. CTRL stays 0xB.
- Pause and register rules:
  - In mode 0 with PRESET=100, write CTRL=0x0 when COUNT=60 → COUNT freezes at 59 or 60 per the rule above, and no IRQ.
  - Write COUNT=0x1234 → ignored.
  - Read offset 0xC → 0.
- Masked interrupt: PRESET=2, CTRL=0x1 → IRQ stays 0 after expiry. Then writing CTRL=0x8 clears pending, so IRQ stays 0.
- Collision: in mode 0, write CTRL=0xB on the same edge as INT → CTRL reads 0xB, and periodic operation continues with IRQ pulses.
